mem_arbiter: RTL

Parametrised N-master arbiter for the PicoRV32 native memory interface, sitting between bus masters (CPU, program loader, debug/monitor port) and a single memory slave such as `bram_controller`. It replaces ad-hoc testbench muxing of the memory port with a synthesizable block. Each slave transaction is owned by one master from `valid` until `ready`. Grant order is round-robin by default, or fixed-priority when compiled with the configuration macro.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_picker.sv | 46 ++++
 rtl/mem_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the PicoRV32 memory-port arbiter.
// Build option MEM_ARB_FIXED_PRIO_EN (see mem_arb_picker) selects fixed priority.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MEM_ARB_MAX_MASTERS = 8;

  // Next index modulo n; indices are at most 3 bits since n <= 8.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input logic [3:0] n);
    logic [3:0] nxt;
    nxt = {1'b0, idx} + 4'd1;
    return (nxt >= n) ? 3'd0 : nxt[2:0];
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant picker: round-robin from last_grant+1 by default,
// lowest asserted index when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    winner = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
  end
`else
  logic [2:0] cand;
  logic       found;

  // Walk the ring starting just after the previous owner; first requester wins.
  always_comb begin
    winner = '0;
    any    = |req;
    found  = 1'b0;
    cand   = 3'(last_grant);
    for (int k = 0; k < N; k++) begin
      cand = wrap_inc(cand, 4'(N));
      if (!found && req[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// N-master arbiter for the PicoRV32 native memory interface onto one slave.
// Grant order is round-robin unless built with MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [NUM_MASTERS-1:0]                    m_valid,
  input  logic [NUM_MASTERS-1:0]                    m_instr,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]        m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]        m_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]      m_wstrb,
  output logic [NUM_MASTERS-1:0]                    m_ready,
  output logic [DATA_W-1:0]                         m_rdata,
  output logic                                      s_valid,
  output logic                                      s_instr,
  output logic [ADDR_W-1:0]                         s_addr,
  output logic [DATA_W-1:0]                         s_wdata,
  output logic [DATA_W/8-1:0]                       s_wstrb,
  input  logic                                      s_ready,
  input  logic [DATA_W-1:0]                         s_rdata,
  output logic [$clog2(NUM_MASTERS)-1:0]            grant_idx,
  output logic                                      busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  // Handshake: a master owns the slave from the cycle its m_valid is seen in
  // IDLE until s_ready; m_ready[grant_idx] mirrors s_ready in that window and
  // a master dropping m_valid before s_ready abandons the transaction.

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] grant_d;
  logic [IDX_W-1:0] last_grant, last_d;
  logic [IDX_W-1:0] winner;
  logic             any;

  mem_arb_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (m_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state      <= state_d;
      grant_idx  <= grant_d;
      last_grant <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant_idx;
    last_d  = last_grant;
    case (state)
      IDLE: begin
        if (any) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        // Completion and abort both release ownership and advance the ring.
        if (s_ready || !m_valid[grant_idx]) begin
          state_d = IDLE;
          last_d  = grant_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state == BUSY);
  assign s_valid = busy && m_valid[grant_idx];
  assign s_instr = m_instr[grant_idx];
  assign s_addr  = m_addr[grant_idx];
  assign s_wdata = m_wdata[grant_idx];
  assign s_wstrb = m_wstrb[grant_idx];
  assign m_rdata = s_rdata;

  always_comb begin
    m_ready = '0;
    if (busy && s_ready) m_ready[grant_idx] = 1'b1;
  end

endmodule
